// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and Booth-pair decode for the sequential Booth multiplier
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } booth_op_t;

    // {Q[0], q-1} = 10 starts a run of ones (subtract), 01 ends one (add)
    function automatic booth_op_t decode_pair(input logic q_lsb, input logic q_prev);
        case ({q_lsb, q_prev})
            2'b10:   return OP_SUB;
            2'b01:   return OP_ADD;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth iteration: add/sub then arithmetic shift
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] acc,
    input  logic [WIDTH:0] q,
    input  logic           q_prev,
    input  logic [WIDTH:0] mcand,
    output logic [WIDTH:0] acc_next,
    output logic [WIDTH:0] q_next,
    output logic           q_prev_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case (decode_pair(q[0], q_prev))
            OP_ADD:  sum = acc + mcand;
            OP_SUB:  sum = acc - mcand;
            default: sum = acc;
        endcase
        {acc_next, q_next, q_prev_next} = {sum[WIDTH], sum, q};
    end

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier, signed/unsigned, start/ready handshake
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic                 abort_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t         state, state_next;
    logic [WIDTH:0] acc, q, mcand;
    logic [WIDTH:0] acc_step, q_step;
    logic           q_prev, q_prev_step;
    logic [CW-1:0]  count;
    logic           accept, last;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .q           (q),
        .q_prev      (q_prev),
        .mcand       (mcand),
        .acc_next    (acc_step),
        .q_next      (q_step),
        .q_prev_next (q_prev_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // abort takes priority over the final iteration
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (count == CW'(WIDTH)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            q        <= '0;
            mcand    <= '0;
            q_prev   <= 1'b0;
            count    <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= last;
            if (accept) begin
                acc    <= '0;
                q_prev <= 1'b0;
                count  <= '0;
                q      <= {signed_i & multiplier_i[WIDTH-1], multiplier_i};
                mcand  <= {signed_i & multiplicand_i[WIDTH-1], multiplicand_i};
            end else if (state == CALC && !abort_i) begin
                acc    <= acc_step;
                q      <= q_step;
                q_prev <= q_prev_step;
                count  <= count + CW'(1);
            end
            if (last) result_o <= {acc_step[WIDTH-2:0], q_step};
        end
    end

    assign ready_o = (state == IDLE);
    assign busy_o  = ~ready_o;

endmodule
